// File: rtl/core_lsu.sv
// Load/store unit: runs decode-stage memory requests on a req/ack data bus,
// builds store byte lanes, extends load data and writes it back to the register file.
module core_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_in,
  input  logic        rw_in,
  input  logic [31:0] addr_in,
  input  logic [2:0]  func3_in,
  input  logic [31:0] wdata_in,
  input  logic [4:0]  rd_in,
  output logic        stall_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_be_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in,
  output logic        wb_we_out,
  output logic [4:0]  wb_addr_out,
  output logic [31:0] wb_data_out,
  output logic        misaligned_out,
  output logic        fault_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;

  logic        op_rw_q;
  logic [2:0]  op_f3_q;
  logic [1:0]  op_off_q;
  logic [4:0]  op_rd_q;

  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        wb_we_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic        misaligned_q;
  logic        fault_q;

  logic        legal;
  logic        aligned;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  bus_be_d;
  logic [31:0] bus_wdata_d;
  logic [31:0] sel;
  logic [31:0] wb_data_d;

  // Decode legality and alignment of the request presented by decode.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    if (rw_in) begin
      legal = (func3_in[2] == 1'b0) && (func3_in[1:0] != 2'b11);
    end else begin
      legal = (func3_in[1:0] != 2'b11) && (func3_in != 3'b110);
    end
    case (func3_in[1:0])
      2'b01:   aligned = ~addr_in[0];
      2'b10:   aligned = (addr_in[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Store lane steering; loads always fetch the full word.
  always_comb begin
    bus_be_d    = 4'b1111;
    bus_wdata_d = '0;
    if (rw_in) begin
      case (func3_in[1:0])
        2'b00: begin
          bus_be_d    = 4'b0001 << addr_in[1:0];
          bus_wdata_d = {4{wdata_in[7:0]}};
        end
        2'b01: begin
          bus_be_d    = 4'b0011 << {addr_in[1], 1'b0};
          bus_wdata_d = {2{wdata_in[15:0]}};
        end
        default: begin
          bus_be_d    = 4'b1111;
          bus_wdata_d = wdata_in;
        end
      endcase
    end
  end

  // Load extraction works on the raw bus word, captured in the ack cycle.
  always_comb begin
    sel       = bus_rdata_in >> {op_off_q, 3'b000};
    wb_data_d = sel;
    case (op_f3_q)
      3'b000:  wb_data_d = {{24{sel[7]}}, sel[7:0]};
      3'b100:  wb_data_d = {24'h000000, sel[7:0]};
      3'b001:  wb_data_d = {{16{sel[15]}}, sel[15:0]};
      3'b101:  wb_data_d = {16'h0000, sel[15:0]};
      default: wb_data_d = sel;
    endcase
  end

  always_comb begin
    accept      = (state_q == S_IDLE) && req_in && legal && aligned;
    timeout_hit = (TMO != 8'd0) && (cnt_q == TMO - 8'd1);
    stall_out   = accept || (state_q == S_BUS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      op_rw_q      <= 1'b0;
      op_f3_q      <= '0;
      op_off_q     <= '0;
      op_rd_q      <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_be_q     <= '0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      fault_q      <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_in) begin
            if (!legal) begin
              fault_q <= 1'b1;
            end else if (!aligned) begin
              misaligned_q <= 1'b1;
            end else begin
              state_q     <= S_BUS;
              cnt_q       <= '0;
              op_rw_q     <= rw_in;
              op_f3_q     <= func3_in;
              op_off_q    <= addr_in[1:0];
              op_rd_q     <= rd_in;
              bus_req_q   <= 1'b1;
              bus_we_q    <= rw_in;
              bus_addr_q  <= {addr_in[31:2], 2'b00};
              bus_wdata_q <= bus_wdata_d;
              bus_be_q    <= bus_be_d;
            end
          end
        end
        S_BUS: begin
          // An ack arriving in the same cycle the budget runs out still completes.
          if (bus_ack_in) begin
            state_q     <= S_DONE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            if (!op_rw_q && (op_rd_q != 5'd0)) begin
              wb_we_q   <= 1'b1;
              wb_addr_q <= op_rd_q;
              wb_data_q <= wb_data_d;
            end
          end else if (timeout_hit) begin
            state_q     <= S_ERR;
            fault_q     <= 1'b1;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_req_out    = bus_req_q;
  assign bus_we_out     = bus_we_q;
  assign bus_addr_out   = bus_addr_q;
  assign bus_wdata_out  = bus_wdata_q;
  assign bus_be_out     = bus_be_q;
  assign wb_we_out      = wb_we_q;
  assign wb_addr_out    = wb_addr_q;
  assign wb_data_out    = wb_data_q;
  assign misaligned_out = misaligned_q;
  assign fault_out      = fault_q;

endmodule

// File: tb/tb_core_lsu.sv
// Bench for core_lsu: directed table of transactions, async-reset sequence,
// then random transactions checked against a byte-level reference model.
module tb_core_lsu;

  localparam int unsigned TMO = 4;
  localparam int K_OK  = 0;
  localparam int K_MIS = 1;
  localparam int K_FLT = 2;
  localparam int K_TMO = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_in;
  logic        rw_in;
  logic [31:0] addr_in;
  logic [2:0]  func3_in;
  logic [31:0] wdata_in;
  logic [4:0]  rd_in;
  logic        stall_out;
  logic        bus_req_out;
  logic        bus_we_out;
  logic [31:0] bus_addr_out;
  logic [31:0] bus_wdata_out;
  logic [3:0]  bus_be_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;
  logic        wb_we_out;
  logic [4:0]  wb_addr_out;
  logic [31:0] wb_data_out;
  logic        misaligned_out;
  logic        fault_out;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  core_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .rw_in(rw_in), .addr_in(addr_in),
    .func3_in(func3_in), .wdata_in(wdata_in), .rd_in(rd_in), .stall_out(stall_out),
    .bus_req_out(bus_req_out), .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
    .bus_wdata_out(bus_wdata_out), .bus_be_out(bus_be_out), .bus_ack_in(bus_ack_in),
    .bus_rdata_in(bus_rdata_in), .wb_we_out(wb_we_out), .wb_addr_out(wb_addr_out),
    .wb_data_out(wb_data_out), .misaligned_out(misaligned_out), .fault_out(fault_out)
  );

  typedef struct {
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    int unsigned dly;
    logic [31:0] rdata;
    int          kind;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic        ewe;
    logic [31:0] ewb;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request viewed as a run of bytes within the word.
  task automatic model(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input int unsigned dly,
                       input logic [31:0] rdata, output int kind, output logic [3:0] ebe,
                       output logic [31:0] ewd, output logic ewe, output logic [31:0] ewb);
    int unsigned sz;
    int unsigned off;
    bit          is_legal;
    longint      v;
    sz  = 1;
    off = int'(addr[1:0]);
    if (rw) is_legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    else    is_legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if (is_legal) sz = 1 << int'(f3[1:0]);
    ebe = 4'hF;
    ewd = '0;
    ewb = '0;
    if (!is_legal)          kind = K_FLT;
    else if (off % sz != 0) kind = K_MIS;
    else if (dly >= TMO)    kind = K_TMO;
    else                    kind = K_OK;
    if (kind == K_OK || kind == K_TMO) begin
      if (rw) begin
        for (int i = 0; i < 4; i++) begin
          ebe[i] = (i >= int'(off)) && (i < int'(off + sz));
          ewd[8*i +: 8] = wd[8*(i % int'(sz)) +: 8];
        end
      end else begin
        v = 0;
        for (int k = 0; k < int'(sz); k++)
          v += longint'(rdata[8*(int'(off) + k) +: 8]) << (8 * k);
        if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
          v -= (longint'(1) << (8 * sz));
        ewb = v[31:0];
      end
    end
    ewe = !rw && (rd != 0) && (kind == K_OK);
  endtask

  // Entered and left at #1 after a rising edge with the DUT in IDLE.
  task automatic do_txn(input logic rw, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int unsigned dly,
                        input logic [31:0] rdata, input int kind, input logic [3:0] ebe,
                        input logic [31:0] ewd, input logic ewe, input logic [31:0] ewb);
    int unsigned nbus;
    req_in = 1'b1; rw_in = rw; func3_in = f3; addr_in = addr; wdata_in = wd; rd_in = rd;
    #1;
    chk("stall_accept", 32'(stall_out), 32'(kind == K_OK || kind == K_TMO));
    @(posedge clk); #1;
    if (kind == K_MIS || kind == K_FLT) begin
      req_in = 1'b0;
      #1;
      chk("misaligned_pulse", 32'(misaligned_out), 32'(kind == K_MIS));
      chk("fault_pulse", 32'(fault_out), 32'(kind == K_FLT));
      chk("no_bus_req", 32'(bus_req_out), 32'd0);
      chk("no_stall", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      chk("pulse_cleared", 32'({misaligned_out, fault_out}), 32'd0);
      return;
    end
    // Decode keeps presenting junk while busy; it must be ignored.
    req_in = 1'b1; rw_in = ~rw; func3_in = 3'd2; addr_in = ~addr & 32'hFFFF_FFFC;
    wdata_in = ~wd; rd_in = ~rd;
    nbus = (kind == K_TMO) ? TMO : dly + 1;
    for (int unsigned c = 0; c < nbus; c++) begin
      chk("bus_req", 32'(bus_req_out), 32'd1);
      chk("bus_we", 32'(bus_we_out), 32'(rw));
      chk("bus_addr", bus_addr_out, {addr[31:2], 2'b00});
      chk("bus_be", 32'(bus_be_out), 32'(ebe));
      chk("bus_wdata", bus_wdata_out, ewd);
      chk("stall_bus", 32'(stall_out), 32'd1);
      chk("wb_idle_bus", 32'(wb_we_out), 32'd0);
      if (kind == K_OK && c == dly) begin
        bus_ack_in = 1'b1; bus_rdata_in = rdata;
      end else begin
        bus_ack_in = 1'b0; bus_rdata_in = $urandom;
      end
      @(posedge clk); #1;
      bus_ack_in = 1'b0; bus_rdata_in = $urandom;
    end
    chk("bus_req_dropped", 32'(bus_req_out), 32'd0);
    chk("stall_after", 32'(stall_out), 32'd0);
    if (kind == K_TMO) begin
      chk("timeout_fault", 32'(fault_out), 32'd1);
      chk("timeout_no_wb", 32'(wb_we_out), 32'd0);
    end else begin
      chk("done_no_fault", 32'(fault_out), 32'd0);
      chk("wb_we", 32'(wb_we_out), 32'(ewe));
      if (ewe) begin
        chk("wb_addr", 32'(wb_addr_out), 32'(rd));
        chk("wb_data", wb_data_out, ewb);
      end
    end
    @(posedge clk); #1;
    req_in = 1'b0;
    chk("idle_clean", 32'({wb_we_out, fault_out, bus_req_out}), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    do_txn(v.rw, v.f3, v.addr, v.wd, v.rd, v.dly, v.rdata, v.kind, v.ebe, v.ewd, v.ewe, v.ewb);
  endtask

  initial begin
    vec_t        r;
    int          kind;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic        ewe;
    logic [31:0] ewb;

    tbl[0]  = '{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0,  2,   32'h0,        K_OK,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        5'd5,  0,   32'h80FF1234, K_OK,  4'hF, 32'h0,        1'b1, 32'hFFFFFF80};
    tbl[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        5'd5,  0,   32'h80FF1234, K_OK,  4'hF, 32'h0,        1'b1, 32'h00000080};
    tbl[3]  = '{1'b1, 3'd1, 32'h202, 32'h0000ABCD, 5'd0,  1,   32'h0,        K_OK,  4'hC, 32'hABCDABCD, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 3'd5, 32'h202, 32'h0,        5'd9,  1,   32'h9876ABCD, K_OK,  4'hF, 32'h0,        1'b1, 32'h00009876};
    tbl[5]  = '{1'b0, 3'd2, 32'h101, 32'h0,        5'd4,  0,   32'h0,        K_MIS, 4'h0, 32'h0,        1'b0, 32'h0};
    tbl[6]  = '{1'b0, 3'd3, 32'h100, 32'h0,        5'd4,  0,   32'h0,        K_FLT, 4'h0, 32'h0,        1'b0, 32'h0};
    tbl[7]  = '{1'b0, 3'd2, 32'h40,  32'h0,        5'd6,  255, 32'h0,        K_TMO, 4'hF, 32'h0,        1'b0, 32'h0};
    tbl[8]  = '{1'b0, 3'd2, 32'h44,  32'h0,        5'd0,  0,   32'h12345678, K_OK,  4'hF, 32'h0,        1'b0, 32'h0};
    tbl[9]  = '{1'b0, 3'd1, 32'h200, 32'h0,        5'd7,  2,   32'h12348001, K_OK,  4'hF, 32'h0,        1'b1, 32'hFFFF8001};
    tbl[10] = '{1'b1, 3'd0, 32'h301, 32'h11223344, 5'd3,  0,   32'h0,        K_OK,  4'h2, 32'h44444444, 1'b0, 32'h0};
    tbl[11] = '{1'b1, 3'd3, 32'h300, 32'h0,        5'd3,  0,   32'h0,        K_FLT, 4'h0, 32'h0,        1'b0, 32'h0};
    tbl[12] = '{1'b0, 3'd2, 32'h80,  32'h0,        5'd31, 3,   32'hCAFEF00D, K_OK,  4'hF, 32'h0,        1'b1, 32'hCAFEF00D};
    tbl[13] = '{1'b1, 3'd1, 32'h203, 32'h0,        5'd0,  0,   32'h0,        K_MIS, 4'h0, 32'h0,        1'b0, 32'h0};

    rst = 1'b0; req_in = 1'b0; rw_in = 1'b0; addr_in = '0; func3_in = '0; wdata_in = '0;
    rd_in = '0; bus_ack_in = 1'b0; bus_rdata_in = '0;
    #2;
    chk("reset_outputs", {bus_req_out, bus_we_out, bus_be_out, wb_we_out, wb_addr_out,
                          misaligned_out, fault_out, stall_out, 17'd0}, 32'd0);
    chk("reset_bus_addr", bus_addr_out, 32'd0);
    chk("reset_wb_data", wb_data_out, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Asynchronous reset in the middle of a bus transaction.
    req_in = 1'b1; rw_in = 1'b0; func3_in = 3'd2; addr_in = 32'h40; rd_in = 5'd3;
    @(posedge clk); #1;
    req_in = 1'b0;
    chk("rst_seq_bus_req", 32'(bus_req_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_bus_req", 32'(bus_req_out), 32'd0);
    chk("async_rst_outputs", {bus_we_out, bus_be_out, wb_we_out, wb_addr_out,
                              misaligned_out, fault_out, stall_out, 18'd0}, 32'd0);
    chk("async_rst_bus_addr", bus_addr_out, 32'd0);
    bus_ack_in = 1'b1; bus_rdata_in = 32'h5555AAAA;
    @(posedge clk); @(negedge clk);
    bus_ack_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_wb", 32'({wb_we_out, bus_req_out, fault_out}), 32'd0);
    model(1'b0, 3'd2, 32'h40, 32'h0, 5'd3, 1, 32'h13572468, kind, ebe, ewd, ewe, ewb);
    do_txn(1'b0, 3'd2, 32'h40, 32'h0, 5'd3, 1, 32'h13572468, kind, ebe, ewd, ewe, ewb);
    model(1'b0, 3'd2, 32'h48, 32'h0, 5'd0, 0, 32'hFFFFFFFF, kind, ebe, ewd, ewe, ewb);
    do_txn(1'b0, 3'd2, 32'h48, 32'h0, 5'd0, 0, 32'hFFFFFFFF, kind, ebe, ewd, ewe, ewb);

    for (int n = 0; n < 300; n++) begin
      r.rw    = 1'($urandom);
      r.f3    = 3'($urandom_range(0, 7));
      r.addr  = $urandom;
      r.wd    = $urandom;
      r.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      r.dly   = $urandom_range(0, 5);
      r.rdata = $urandom;
      model(r.rw, r.f3, r.addr, r.wd, r.rd, r.dly, r.rdata, kind, ebe, ewd, ewe, ewb);
      do_txn(r.rw, r.f3, r.addr, r.wd, r.rd, r.dly, r.rdata, kind, ebe, ewd, ewe, ewb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
